fpu_share_arbiter: RTL and testbench

- Shares one multi-cycle FPU instance (fpnew_top interface, single operation in flight) between NUM_REQ requesters. Typical requesters are the issue-stage FP path and a vector/helper unit.
- Round-robin arbitration, one outstanding operation, in-order response routing back to the granted requester.
- Stale results that arrive after a flush are discarded using a one-bit sequence tag.
- Sits between the requesters and the fpnew_top handshake ports.

---
 rtl/fpu_arb_pkg.sv | 25 ++
 rtl/fpu_rr_picker.sv | 34 +++
 rtl/fpu_share_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU share arbiter and its round-robin picker.
package fpu_arb_pkg;

    localparam int STATUS_W     = 5;
    localparam int RSP_RESULT_W = 64;
    localparam int RSP_RTAG_W   = 5;

    // Reported on a watchdog expiry: invalid-operation flag only.
    localparam logic [STATUS_W-1:0] TIMEOUT_STATUS = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    // WIDTH and RTAG_W of the top must not exceed these field widths.
    typedef struct packed {
        logic [RSP_RESULT_W-1:0] result;
        logic [STATUS_W-1:0]     status;
        logic [RSP_RTAG_W-1:0]   rtag;
    } rsp_t;

endpackage

// File: rtl/fpu_rr_picker.sv
// Combinational round-robin picker: first asserted valid at or after rr_ptr_i, wrapping.
module fpu_rr_picker
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
)(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               found_o
);

    int               idx;
    logic [IDX_W-1:0] idxSel;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = 0;
        idxSel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idxSel = idx[IDX_W-1:0];
            if (!found_o && valid_i[idxSel]) begin
                found_o  = 1'b1;
                winner_o = idxSel;
            end
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one single-operation FPU between NUM_REQ requesters with round-robin grant.
// Define FPU_ARB_TIMEOUT_EN to add the WAIT watchdog and the sticky timeout_o port.
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int WIDTH          = 64,
    parameter int PAYLOAD_W      = 220,
    parameter int RTAG_W         = 5,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
    input  logic [NUM_REQ*RTAG_W-1:0]    req_tag_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [WIDTH-1:0]         rsp_result_o,
    output logic [STATUS_W-1:0]      rsp_status_o,
    output logic [RTAG_W-1:0]        rsp_tag_o,
    output logic                     fpu_valid_o,
    input  logic                     fpu_ready_i,
    output logic [PAYLOAD_W-1:0]     fpu_payload_o,
    output logic                     fpu_tag_o,
    input  logic                     fpu_out_valid_i,
    output logic                     fpu_out_ready_o,
    input  logic [WIDTH-1:0]         fpu_result_i,
    input  logic [STATUS_W-1:0]      fpu_status_i,
    input  logic                     fpu_tag_i,
    output logic                     fpu_flush_o,
    input  logic                     flush_i,
    output logic                     busy_o
`ifdef FPU_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_o
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic                   seq_q, seq_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    rsp_t                   rsp_q, rsp_d;
    logic                   fpu_flush_q, fpu_flush_d;
    logic [IDX_W-1:0]       winner;
    logic                   found;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
`endif

    fpu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid_i  (req_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            seq_q       <= 1'b0;
            payload_q   <= '0;
            rsp_q       <= '0;
            fpu_flush_q <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            seq_q       <= seq_d;
            payload_q   <= payload_d;
            rsp_q       <= rsp_d;
            fpu_flush_q <= fpu_flush_d;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // seq toggles per accepted request and is never rewound, so results of a flushed op mismatch.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        seq_d       = seq_q;
        payload_d   = payload_q;
        rsp_d       = rsp_q;
        fpu_flush_d = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
`endif
        if (flush_i) begin
            if (state_q != IDLE) begin
                state_d     = IDLE;
                fpu_flush_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_d    = winner;
                        payload_d  = req_payload_i[int'(winner)*PAYLOAD_W +: PAYLOAD_W];
                        rsp_d.rtag = RSP_RTAG_W'(req_tag_i[int'(winner)*RTAG_W +: RTAG_W]);
                        seq_d      = ~seq_q;
                        state_d    = ISSUE;
                    end
                end
                ISSUE: begin
                    if (fpu_ready_i) begin
                        state_d = WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                WAIT: begin
                    if (fpu_out_valid_i && (fpu_tag_i == seq_q)) begin
                        rsp_d.result = RSP_RESULT_W'(fpu_result_i);
                        rsp_d.status = fpu_status_i;
                        state_d      = RESP;
                    end
`ifdef FPU_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_d.result = '1;
                        rsp_d.status = TIMEOUT_STATUS;
                        timeout_d    = 1'b1;
                        fpu_flush_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i[grant_q]) begin
                        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o     = '0;
        rsp_valid_o     = '0;
        fpu_valid_o     = 1'b0;
        fpu_out_ready_o = 1'b0;
        case (state_q)
            IDLE:    if (found && !flush_i) req_ready_o[winner] = 1'b1;
            ISSUE:   fpu_valid_o = 1'b1;
            WAIT:    fpu_out_ready_o = 1'b1;
            RESP:    if (!flush_i) rsp_valid_o[grant_q] = 1'b1;
            default: ;
        endcase
    end

    assign fpu_payload_o = payload_q;
    assign fpu_tag_o     = seq_q;
    assign fpu_flush_o   = fpu_flush_q;
    assign rsp_result_o  = rsp_q.result[WIDTH-1:0];
    assign rsp_status_o  = rsp_q.status;
    assign rsp_tag_o     = rsp_q.rtag[RTAG_W-1:0];
    assign busy_o        = (state_q != IDLE);
`ifdef FPU_ARB_TIMEOUT_EN
    assign timeout_o     = timeout_q;
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Self-checking bench for fpu_share_arbiter: arbitration table, directed corner cases, random ops.
// Timeout checks are compiled in when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_share_arbiter;

    localparam int NR = 2;
    localparam int W  = 64;
    localparam int PW = 220;
    localparam int TW = 5;
    localparam int TO = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*PW-1:0]  req_payload_i;
    logic [NR*TW-1:0]  req_tag_i;
    logic [NR-1:0]     rsp_valid_o;
    logic [NR-1:0]     rsp_ready_i;
    logic [W-1:0]      rsp_result_o;
    logic [4:0]        rsp_status_o;
    logic [TW-1:0]     rsp_tag_o;
    logic              fpu_valid_o;
    logic              fpu_ready_i;
    logic [PW-1:0]     fpu_payload_o;
    logic              fpu_tag_o;
    logic              fpu_out_valid_i;
    logic              fpu_out_ready_o;
    logic [W-1:0]      fpu_result_i;
    logic [4:0]        fpu_status_i;
    logic              fpu_tag_i;
    logic              fpu_flush_o;
    logic              flush_i;
    logic              busy_o;
`ifdef FPU_ARB_TIMEOUT_EN
    logic              timeout_o;
`endif

    always #5 clk_i = ~clk_i;

    fpu_share_arbiter #(
        .NUM_REQ        (NR),
        .WIDTH          (W),
        .PAYLOAD_W      (PW),
        .RTAG_W         (TW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_payload_i   (req_payload_i),
        .req_tag_i       (req_tag_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_status_o    (rsp_status_o),
        .rsp_tag_o       (rsp_tag_o),
        .fpu_valid_o     (fpu_valid_o),
        .fpu_ready_i     (fpu_ready_i),
        .fpu_payload_o   (fpu_payload_o),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .fpu_tag_i       (fpu_tag_i),
        .fpu_flush_o     (fpu_flush_o),
        .flush_i         (flush_i),
`ifdef FPU_ARB_TIMEOUT_EN
        .timeout_o       (timeout_o),
`endif
        .busy_o          (busy_o)
    );

    typedef struct {
        int            ptr;
        logic [NR-1:0] valid;
        logic          flush;
        logic [NR-1:0] expReady;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int             testsRun    = 0;
    int             testsFailed = 0;
    int             modelPtr    = 0;
    logic           modelSeq    = 1'b0;
    logic [PW-1:0]  expPayload;
    logic [TW-1:0]  expRtag;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid_i = v.valid;
        flush_i     = v.flush;
    endtask

    // Reference arbitration: first valid requester at or after ptr, modulo NR.
    function automatic int modelPick(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [PW-1:0] randPayload();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        return t[PW-1:0];
    endfunction

    task automatic randomizeRequests();
        for (int p = 0; p < NR; p++) begin
            req_payload_i[p*PW +: PW] = randPayload();
            req_tag_i[p*TW +: TW]     = TW'($urandom);
        end
    endtask

    task automatic runTable(input int ptr);
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].ptr == ptr) begin
                applyStimulus(vecs[i]);
                @(negedge clk_i);
                checkOutput("table_ready", req_ready_o, vecs[i].expReady);
                checkOutput("table_busy", busy_o, 0);
                #1;
                req_valid_i = '0;
                flush_i     = 1'b0;
                stepCycle();
            end
        end
    endtask

    task automatic acceptOp(input logic [NR-1:0] mask, input bit keep, output int win);
        win = modelPick(mask, modelPtr);
        req_valid_i = mask;
        @(negedge clk_i);
        checkOutput("accept_ready", req_ready_o, NR'(1) << win);
        expPayload = req_payload_i[win*PW +: PW];
        expRtag    = req_tag_i[win*TW +: TW];
        stepCycle();
        if (!keep) req_valid_i = '0;
        modelSeq = ~modelSeq;
    endtask

    task automatic checkFlushPulse();
        @(negedge clk_i);
        checkOutput("flush_pulse", fpu_flush_o, 1);
        checkOutput("flush_idle", busy_o, 0);
        checkOutput("flush_fpu_valid", fpu_valid_o, 0);
        checkOutput("flush_no_rsp", rsp_valid_o, 0);
        stepCycle();
        @(negedge clk_i);
        checkOutput("flush_pulse_end", fpu_flush_o, 0);
        stepCycle();
    endtask

    task automatic issueOp(input int readyDelay, input bit flushHere);
        for (int i = 0; i <= readyDelay; i++) begin
            if (i == readyDelay) begin
                if (flushHere) flush_i = 1'b1;
                else           fpu_ready_i = 1'b1;
            end
            @(negedge clk_i);
            checkOutput("issue_valid", fpu_valid_o, 1);
            checkOutput("issue_tag", fpu_tag_o, modelSeq);
            checkOutput("issue_payload", fpu_payload_o, expPayload);
            checkOutput("issue_no_ready", req_ready_o, 0);
            stepCycle();
        end
        fpu_ready_i = 1'b0;
        if (flushHere) begin
            flush_i = 1'b0;
            checkFlushPulse();
        end
    endtask

    task automatic returnOp(input int latency, input bit stale, input logic [W-1:0] res,
                            input logic [4:0] st, input bit flushHere);
        for (int i = 0; i < latency; i++) begin
            @(negedge clk_i);
            checkOutput("wait_out_ready", fpu_out_ready_o, 1);
            checkOutput("wait_no_rsp", rsp_valid_o, 0);
            stepCycle();
        end
        if (stale) begin
            fpu_out_valid_i = 1'b1;
            fpu_tag_i       = ~modelSeq;
            fpu_result_i    = ~res;
            fpu_status_i    = 5'h1F;
            stepCycle();
            fpu_out_valid_i = 1'b0;
            @(negedge clk_i);
            checkOutput("stale_dropped", rsp_valid_o, 0);
            checkOutput("stale_still_wait", fpu_out_ready_o, 1);
            stepCycle();
        end
        fpu_out_valid_i = 1'b1;
        fpu_tag_i       = modelSeq;
        fpu_result_i    = res;
        fpu_status_i    = st;
        flush_i         = flushHere;
        stepCycle();
        fpu_out_valid_i = 1'b0;
        flush_i         = 1'b0;
        if (flushHere) checkFlushPulse();
    endtask

    task automatic respondOp(input int win, input int rspDelay, input logic [W-1:0] res, input logic [4:0] st);
        for (int i = 0; i <= rspDelay; i++) begin
            if (i == rspDelay) rsp_ready_i = NR'(1) << win;
            @(negedge clk_i);
            checkOutput("rsp_valid", rsp_valid_o, NR'(1) << win);
            checkOutput("rsp_result", rsp_result_o, res);
            checkOutput("rsp_status", rsp_status_o, st);
            checkOutput("rsp_tag", rsp_tag_o, expRtag);
            checkOutput("rsp_no_ready", req_ready_o, 0);
            checkOutput("rsp_out_ready", fpu_out_ready_o, 0);
            stepCycle();
        end
        rsp_ready_i = '0;
        modelPtr = (win + 1) % NR;
        checkOutput("rsp_done_idle", busy_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int win;
        logic [W-1:0] res;
        logic [4:0]   st;

        vecs[0] = '{0, 2'b00, 1'b0, 2'b00};
        vecs[1] = '{0, 2'b01, 1'b0, 2'b01};
        vecs[2] = '{0, 2'b10, 1'b0, 2'b10};
        vecs[3] = '{0, 2'b11, 1'b0, 2'b01};
        vecs[4] = '{0, 2'b11, 1'b1, 2'b00};
        vecs[5] = '{1, 2'b00, 1'b0, 2'b00};
        vecs[6] = '{1, 2'b01, 1'b0, 2'b01};
        vecs[7] = '{1, 2'b10, 1'b0, 2'b10};
        vecs[8] = '{1, 2'b11, 1'b0, 2'b10};
        vecs[9] = '{1, 2'b10, 1'b1, 2'b00};

        rst_ni          = 1'b1;
        req_valid_i     = '0;
        req_payload_i   = '0;
        req_tag_i       = '0;
        rsp_ready_i     = '0;
        fpu_ready_i     = 1'b0;
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = '0;
        fpu_status_i    = '0;
        fpu_tag_i       = 1'b0;
        flush_i         = 1'b0;
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_rsp_valid", rsp_valid_o, 0);
        checkOutput("reset_req_ready", req_ready_o, 0);
        checkOutput("reset_fpu_valid", fpu_valid_o, 0);
        checkOutput("reset_out_ready", fpu_out_ready_o, 0);
        checkOutput("reset_flush", fpu_flush_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_result", rsp_result_o, 0);
        checkOutput("reset_status", rsp_status_o, 0);
        checkOutput("reset_rtag", rsp_tag_o, 0);
        checkOutput("reset_fpu_tag", fpu_tag_o, 0);
        checkOutput("reset_payload", fpu_payload_o, 0);
`ifdef FPU_ARB_TIMEOUT_EN
        checkOutput("reset_timeout", timeout_o, 0);
`endif
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        stepCycle();

        runTable(modelPtr);

        // Single op on port 0, result four cycles after issue.
        randomizeRequests();
        req_tag_i[0 +: TW] = 5'h0A;
        acceptOp(2'b01, 0, win);
        issueOp(0, 0);
        returnOp(3, 0, 64'h3FF0_0000_0000_0000, 5'h00, 0);
        respondOp(win, 0, 64'h3FF0_0000_0000_0000, 5'h00);

        runTable(modelPtr);

        // Both requesters valid continuously: grants must alternate.
        for (int i = 0; i < 4; i++) begin
            randomizeRequests();
            res = {$urandom, $urandom};
            st  = 5'($urandom);
            acceptOp(2'b11, 1, win);
            issueOp(0, 0);
            returnOp(1, 0, res, st, 0);
            respondOp(win, 0, res, st);
        end
        req_valid_i = '0;

        // Response back-pressured for 10 cycles with the other requester still waiting.
        randomizeRequests();
        res = {$urandom, $urandom};
        st  = 5'($urandom);
        acceptOp(2'b11, 1, win);
        issueOp(1, 0);
        returnOp(2, 0, res, st, 0);
        respondOp(win, 10, res, st);
        req_valid_i = '0;

        // Flush in WAIT coinciding with the result, then port 1 sees a stale return first.
        randomizeRequests();
        res = {$urandom, $urandom};
        acceptOp(2'b01, 0, win);
        issueOp(0, 0);
        returnOp(1, 0, res, 5'h01, 1);
        randomizeRequests();
        res = {$urandom, $urandom};
        st  = 5'($urandom);
        acceptOp(2'b10, 0, win);
        issueOp(0, 0);
        returnOp(2, 1, res, st, 0);
        respondOp(win, 0, res, st);

        // Flush while the FPU is still refusing the operation.
        randomizeRequests();
        acceptOp(2'b10, 0, win);
        issueOp(2, 1);

`ifdef FPU_ARB_TIMEOUT_EN
        randomizeRequests();
        acceptOp(2'b01, 0, win);
        issueOp(0, 0);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk_i);
            checkOutput("to_wait_ready", fpu_out_ready_o, 1);
            checkOutput("to_no_rsp", rsp_valid_o, 0);
            checkOutput("to_not_yet", timeout_o, 0);
            stepCycle();
        end
        @(negedge clk_i);
        checkOutput("to_flush_pulse", fpu_flush_o, 1);
        checkOutput("to_flag", timeout_o, 1);
        stepCycle();
        respondOp(win, 0, {W{1'b1}}, 5'b10000);
        checkOutput("to_sticky", timeout_o, 1);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [NR-1:0] mask;
            int            mode;
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            randomizeRequests();
            res  = {$urandom, $urandom};
            st   = 5'($urandom);
            mode = int'($urandom_range(0, 7));
            acceptOp(mask, 0, win);
            if (mode == 0) begin
                issueOp(int'($urandom_range(0, 3)), 1);
            end else begin
                issueOp(int'($urandom_range(0, 3)), 0);
                if (mode == 1) begin
                    returnOp(int'($urandom_range(0, 3)), 0, res, st, 1);
                end else begin
                    returnOp(int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), res, st, 0);
                    respondOp(win, int'($urandom_range(0, 3)), res, st);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
